// File: rtl/bcd_timer_ctrl_if.sv
// Control/status bundle between the front-panel logic and the BCD timer controller.
// The master drives the requests; the slave (the timer) reports count and status.
interface bcd_timer_ctrl_if;
  logic       start;
  logic       stop;
  logic       load;
  logic       up_down;
  logic [7:0] data_in;
  logic [7:0] count_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] state;

  modport master (
    output start, stop, load, up_down, data_in,
    input  count_out, busy, done, err, state
  );

  modport slave (
    input  start, stop, load, up_down, data_in,
    output count_out, busy, done, err, state
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD up/down timer: preset load, start/pause/resume, prescaled stepping,
// one-cycle done pulse at the terminal value (99 up, 00 down).
module bcd_timer_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  bcd_timer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  state_t     cur;
  logic [7:0] count;
  logic [7:0] presc;
  logic       dir;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [7:0] stepped;
  logic       data_valid;

  function automatic logic [7:0] terminal(input logic up);
    return up ? 8'h99 : 8'h00;
  endfunction

  // Terminal detection stops counting before any digit could leave 0..9.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up);
    logic [7:0] r;
    r = v;
    if (up) begin
      if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
      else                r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  assign stepped    = bcd_step(count, dir);
  assign data_valid = (bus.data_in[7:4] <= 4'd9) && (bus.data_in[3:0] <= 4'd9);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur    <= IDLE;
      count  <= 8'h00;
      presc  <= 8'h00;
      dir    <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (cur)
        RUN: begin
          if (bus.stop) begin
            cur    <= PAUSE;
            busy_q <= 1'b0;
            presc  <= 8'h00;
          end else if (presc == TICK_LAST) begin
            presc <= 8'h00;
            count <= stepped;
            if (stepped == terminal(dir)) begin
              cur    <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            presc <= presc + 8'd1;
          end
        end
        // IDLE, PAUSE and DONE: load has priority; start is only honoured outside DONE.
        default: begin
          if (bus.load) begin
            if (data_valid) begin
              count <= bus.data_in;
              cur   <= IDLE;
            end else begin
              err_q <= 1'b1;
            end
          end else if (cur != DONE && bus.start && !bus.stop) begin
            dir   <= bus.up_down;
            presc <= 8'h00;
            if (count == terminal(bus.up_down)) begin
              cur    <= DONE;
              done_q <= 1'b1;
            end else begin
              cur    <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.count_out = count;
  assign bus.state     = cur;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
